// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : bus_interconnect
// Brief    : N-master / M-slave shared bus with arbitration, address decode,
//            ready timeout and one-cycle transfer strobe.
// Revision : 1.0 - initial release
// ============================================================================
module bus_interconnect #(
    parameter int                          NUM_MASTERS     = 4,
    parameter int                          NUM_SLAVES      = 2,
    parameter int                          ADDR_W          = 16,
    parameter int                          DATA_W          = 16,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE     = '0,
    parameter int                          CLK_MAX_TIMEOUT = 12,
    parameter int                          ARB_MODE        = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        barq_i,
    output logic [NUM_MASTERS-1:0]        bagd_o,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
    input  logic [NUM_MASTERS-1:0]        m_rw_i,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic [NUM_SLAVES-1:0]         s_sel_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic                          s_rw_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i,
    input  logic [NUM_SLAVES-1:0]         s_ready_i,
    output logic                          data_strobe_o,
    output logic                          error_o,
    output logic [1:0]                    error_code_o
);

    localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_CNT_W = (CLK_MAX_TIMEOUT < 2) ? 1 : $clog2(CLK_MAX_TIMEOUT + 1);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_GRANT   = 3'd1;
    localparam logic [2:0] c_S_WAIT    = 3'd2;
    localparam logic [2:0] c_S_STROBE  = 3'd3;
    localparam logic [2:0] c_S_RELEASE = 3'd4;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_DECODE  = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    logic [2:0]             r_state;
    logic [2:0]             w_state_next;
    logic [NUM_MASTERS-1:0] r_bagd;
    logic [NUM_SLAVES-1:0]  r_sel;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_error;
    logic [1:0]             r_err_code;
    logic [c_CNT_W-1:0]     r_wait_cnt;
    logic [c_IDX_W-1:0]     r_rr_ptr;

    logic [NUM_MASTERS-1:0] w_winner;
    logic [c_IDX_W-1:0]     w_winner_idx;
    logic                   w_found;
    logic [NUM_SLAVES-1:0]  w_hit;
    logic                   w_hit_any;
    logic                   w_ready;
    logic [DATA_W-1:0]      w_rdata;
    logic                   w_timeout;

    // Arbiter: round-robin rotates the search start past the last winner.
    always_comb begin
        int w_cand;
        w_winner     = '0;
        w_winner_idx = '0;
        w_found      = 1'b0;
        w_cand       = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand = (ARB_MODE == 1) ? ((int'(r_rr_ptr) + 1 + k) % NUM_MASTERS) : k;
            if (!w_found && barq_i[w_cand]) begin
                w_found          = 1'b1;
                w_winner[w_cand] = 1'b1;
                w_winner_idx     = c_IDX_W'(w_cand);
            end
        end
    end

    // Granted-master mux; all zero while nobody holds the bus.
    always_comb begin
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_rw_o    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_bagd[i]) begin
                s_addr_o  = s_addr_o  | m_addr_i[i*ADDR_W +: ADDR_W];
                s_wdata_o = s_wdata_o | m_wdata_i[i*DATA_W +: DATA_W];
                s_rw_o    = s_rw_o    | m_rw_i[i];
            end
        end
    end

    // Address decode, one bit wider so BASE+SIZE-1 cannot wrap.
    always_comb begin
        logic [ADDR_W:0] w_base;
        logic [ADDR_W:0] w_last;
        w_hit     = '0;
        w_hit_any = 1'b0;
        w_base    = '0;
        w_last    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_base = {1'b0, SLAVE_BASE[i*ADDR_W +: ADDR_W]};
            w_last = w_base + {1'b0, SLAVE_SIZE[i*ADDR_W +: ADDR_W]} - (ADDR_W+1)'(1);
            if (!w_hit_any && (SLAVE_SIZE[i*ADDR_W +: ADDR_W] != '0) &&
                ({1'b0, s_addr_o} >= w_base) && ({1'b0, s_addr_o} <= w_last)) begin
                w_hit[i]  = 1'b1;
                w_hit_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) begin
                w_rdata = w_rdata | s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ready   = |(s_ready_i & r_sel);
    assign w_timeout = ((r_wait_cnt + c_CNT_W'(1)) == c_CNT_W'(CLK_MAX_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ready in the last wait cycle wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:    if (w_found) w_state_next = c_S_GRANT;
            c_S_GRANT:   w_state_next = w_hit_any ? c_S_WAIT : c_S_RELEASE;
            c_S_WAIT: begin
                if (w_ready) begin
                    w_state_next = c_S_STROBE;
                end else if (w_timeout) begin
                    w_state_next = c_S_RELEASE;
                end
            end
            c_S_STROBE:  w_state_next = c_S_RELEASE;
            c_S_RELEASE: w_state_next = c_S_IDLE;
            default:     w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        data_strobe_o = (r_state == c_S_STROBE);
        bagd_o        = r_bagd;
        s_sel_o       = r_sel;
        m_rdata_o     = r_rdata;
        error_o       = r_error;
        error_code_o  = r_err_code;
    end

    // Grant and select are dropped on the way into RELEASE so they read 0 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bagd     <= '0;
            r_sel      <= '0;
            r_rdata    <= '0;
            r_error    <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_wait_cnt <= '0;
            r_rr_ptr   <= c_IDX_W'(NUM_MASTERS - 1);
        end else begin
            r_error <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_bagd   <= w_winner;
                        r_rr_ptr <= w_winner_idx;
                    end
                end
                c_S_GRANT: begin
                    r_wait_cnt <= '0;
                    if (w_hit_any) begin
                        r_sel <= w_hit;
                    end else begin
                        r_error    <= 1'b1;
                        r_err_code <= c_ERR_DECODE;
                        r_bagd     <= '0;
                    end
                end
                c_S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    if (!w_ready && w_timeout) begin
                        r_error    <= 1'b1;
                        r_err_code <= c_ERR_TIMEOUT;
                        r_bagd     <= '0;
                        r_sel      <= '0;
                    end
                end
                c_S_STROBE: begin
                    if (!s_rw_o) begin
                        r_rdata <= w_rdata;
                    end
                    r_err_code <= c_ERR_NONE;
                    r_bagd     <= '0;
                    r_sel      <= '0;
                end
                default: begin
                    r_bagd <= '0;
                    r_sel  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_interconnect
// Brief    : Directed bench: read, decode miss, timeout, ready-vs-timeout,
//            async reset abort and both arbitration modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam logic [NS*AW-1:0] c_BASE = {16'h0100, 16'h0000};
    localparam logic [NS*AW-1:0] c_SIZE = {16'h0010, 16'h0100};

    logic          clk;
    logic          rst_n;
    logic [NM-1:0] barq;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0] m_rw;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0] s_ready;

    logic [NM-1:0] bagd, rr_bagd;
    logic [DW-1:0] m_rdata, rr_m_rdata;
    logic [NS-1:0] s_sel, rr_s_sel;
    logic [AW-1:0] s_addr, rr_s_addr;
    logic [DW-1:0] s_wdata, rr_s_wdata;
    logic          s_rw, rr_s_rw;
    logic          strobe, rr_strobe;
    logic          err, rr_err;
    logic [1:0]    err_code, rr_err_code;

    int checks = 0;
    int errors = 0;

    bus_interconnect #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .SLAVE_BASE(c_BASE), .SLAVE_SIZE(c_SIZE), .CLK_MAX_TIMEOUT(12), .ARB_MODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .barq_i(barq), .bagd_o(bagd),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rw_i(m_rw), .m_rdata_o(m_rdata),
        .s_sel_o(s_sel), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_rw_o(s_rw),
        .s_rdata_i(s_rdata), .s_ready_i(s_ready), .data_strobe_o(strobe),
        .error_o(err), .error_code_o(err_code)
    );

    bus_interconnect #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .SLAVE_BASE(c_BASE), .SLAVE_SIZE(c_SIZE), .CLK_MAX_TIMEOUT(12), .ARB_MODE(1)
    ) dut_rr (
        .clk(clk), .rst_n(rst_n), .barq_i(barq), .bagd_o(rr_bagd),
        .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rw_i(m_rw), .m_rdata_o(rr_m_rdata),
        .s_sel_o(rr_s_sel), .s_addr_o(rr_s_addr), .s_wdata_o(rr_s_wdata), .s_rw_o(rr_s_rw),
        .s_rdata_i(s_rdata), .s_ready_i(s_ready), .data_strobe_o(rr_strobe),
        .error_o(rr_err), .error_code_o(rr_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        rst_n   = 1'b0;
        barq    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_rw    = '0;
        s_rdata = '0;
        s_ready = '0;
        #12;
        check("rst_bagd", 32'(bagd), 32'h0);
        check("rst_sel", 32'(s_sel), 32'h0);
        check("rst_strobe", 32'(strobe), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_code", 32'(err_code), 32'h0);
        check("rst_rdata", 32'(m_rdata), 32'h0);
        check("rst_saddr", 32'(s_addr), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Master0 read 0x0005 from slave0, ready at first wait cycle.
        m_addr[0*AW +: AW]  = 16'h0005;
        m_rw[0]             = 1'b0;
        s_rdata[0*DW +: DW] = 16'hBEEF;
        s_ready             = 2'b01;
        barq                = 2'b01;
        tick();
        check("rd_grant_bagd", 32'(bagd), 32'h1);
        check("rd_grant_saddr", 32'(s_addr), 32'h0005);
        check("rd_grant_srw", 32'(s_rw), 32'h0);
        check("rd_grant_sel", 32'(s_sel), 32'h0);
        barq = 2'b00;
        tick();
        check("rd_wait_sel", 32'(s_sel), 32'h1);
        check("rd_wait_strobe", 32'(strobe), 32'h0);
        check("rd_wait_err", 32'(err), 32'h0);
        tick();
        check("rd_strobe", 32'(strobe), 32'h1);
        check("rd_strobe_err", 32'(err), 32'h0);
        tick();
        check("rd_rel_strobe", 32'(strobe), 32'h0);
        check("rd_rdata", 32'(m_rdata), 32'hBEEF);
        check("rd_rel_bagd", 32'(bagd), 32'h0);
        check("rd_rel_sel", 32'(s_sel), 32'h0);
        check("rd_rel_err", 32'(err), 32'h0);
        check("rd_code", 32'(err_code), 32'h0);
        tick();

        // Master1 write 0x0110: falls between regions.
        m_addr[1*AW +: AW]  = 16'h0110;
        m_wdata[1*DW +: DW] = 16'hCAFE;
        m_rw[1]             = 1'b1;
        barq                = 2'b10;
        tick();
        check("miss_bagd", 32'(bagd), 32'h2);
        check("miss_srw", 32'(s_rw), 32'h1);
        check("miss_swdata", 32'(s_wdata), 32'hCAFE);
        barq = 2'b00;
        tick();
        check("miss_err", 32'(err), 32'h1);
        check("miss_code", 32'(err_code), 32'h1);
        check("miss_strobe", 32'(strobe), 32'h0);
        check("miss_rel_bagd", 32'(bagd), 32'h0);
        tick();
        check("miss_err_clr", 32'(err), 32'h0);
        check("miss_code_hold", 32'(err_code), 32'h1);
        check("miss_rdata_hold", 32'(m_rdata), 32'hBEEF);

        // Ready arriving in the 12th wait cycle beats the timeout.
        m_addr[0*AW +: AW]  = 16'h0105;
        s_rdata[1*DW +: DW] = 16'h1234;
        s_ready             = 2'b00;
        barq                = 2'b01;
        tick();
        barq = 2'b00;
        tick();
        check("prec_sel", 32'(s_sel), 32'h2);
        repeat (11) tick();
        check("prec_w12_err", 32'(err), 32'h0);
        s_ready = 2'b10;
        tick();
        check("prec_strobe", 32'(strobe), 32'h1);
        check("prec_err", 32'(err), 32'h0);
        s_ready = 2'b00;
        tick();
        check("prec_rdata", 32'(m_rdata), 32'h1234);
        check("prec_code", 32'(err_code), 32'h0);
        tick();

        // Master0 read 0x0100: slave1 never ready, only slave0 is.
        m_addr[0*AW +: AW] = 16'h0100;
        s_ready            = 2'b01;
        barq               = 2'b01;
        tick();
        barq = 2'b00;
        bad  = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (err || strobe) bad++;
        end
        check("to_wait_quiet", 32'(bad), 32'h0);
        check("to_w12_sel", 32'(s_sel), 32'h2);
        tick();
        check("to_err", 32'(err), 32'h1);
        check("to_code", 32'(err_code), 32'h2);
        check("to_strobe", 32'(strobe), 32'h0);
        check("to_bagd", 32'(bagd), 32'h0);
        tick();
        check("to_err_clr", 32'(err), 32'h0);

        // Reset in the middle of a wait.
        m_addr[0*AW +: AW] = 16'h0005;
        s_ready            = 2'b00;
        barq               = 2'b01;
        tick();
        barq = 2'b00;
        tick();
        tick();
        check("ar_pre_sel", 32'(s_sel), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_bagd", 32'(bagd), 32'h0);
        check("ar_sel", 32'(s_sel), 32'h0);
        check("ar_strobe", 32'(strobe), 32'h0);
        check("ar_err", 32'(err), 32'h0);
        check("ar_code", 32'(err_code), 32'h0);
        check("ar_rdata", 32'(m_rdata), 32'h0);
        check("ar_saddr", 32'(s_addr), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_after_err", 32'(err), 32'h0);
        check("ar_after_strobe", 32'(strobe), 32'h0);

        // Master1 read 0x0108 from slave1 after reset.
        m_addr[1*AW +: AW]  = 16'h0108;
        m_rw[1]             = 1'b0;
        s_rdata[1*DW +: DW] = 16'h5A5A;
        s_ready             = 2'b10;
        barq                = 2'b10;
        tick();
        check("post_bagd", 32'(bagd), 32'h2);
        barq = 2'b00;
        tick();
        check("post_sel", 32'(s_sel), 32'h2);
        tick();
        check("post_strobe", 32'(strobe), 32'h1);
        tick();
        check("post_rdata", 32'(m_rdata), 32'h5A5A);
        check("post_code", 32'(err_code), 32'h0);
        tick();

        // Both masters request continuously.
        m_addr  = {16'h0010, 16'h0005};
        m_rw    = 2'b00;
        s_ready = 2'b01;
        barq    = 2'b11;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("arb_rr", 32'(rr_bagd), (g % 2 == 0) ? 32'h1 : 32'h2);
            check("arb_fixed", 32'(bagd), 32'h1);
            repeat (4) tick();
        end
        barq = 2'b00;
        repeat (6) tick();
        check("end_bagd", 32'(bagd), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters (1..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 2, number of decoded slaves (1..8).
REQ-003 SHALL have parameters ADDR_W, default 16, and DATA_W, default 16, as the address and data widths.
REQ-004 SHALL have parameters SLAVE_BASE and SLAVE_SIZE, each NUM_SLAVES*ADDR_W wide, default all-zero, giving the per-slave base address and size in words (slave i at bits [i*ADDR_W +: ADDR_W]).
REQ-005 SHALL have parameter CLK_MAX_TIMEOUT, default 12, the maximum number of wait cycles for slave ready.
REQ-006 SHALL have parameter ARB_MODE, default 0, selecting the arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 SHALL have one clock and one reset: clk, input, 1, sole clock, all logic on its rising edge.
REQ-008 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have barq_i, input, NUM_MASTERS, per-master bus request.
REQ-010 SHALL have bagd_o, output, NUM_MASTERS, one-hot bus grant.
REQ-011 SHALL have m_addr_i, m_wdata_i and m_rw_i, inputs, NUM_MASTERS*ADDR_W, NUM_MASTERS*DATA_W and NUM_MASTERS, carrying each master's address, write data and direction (1 = write).
REQ-012 SHALL have m_rdata_o, output, DATA_W, registered read data returned to the granted master.
REQ-013 SHALL have s_sel_o, output, NUM_SLAVES, one-hot registered slave select.
REQ-014 SHALL have s_addr_o, s_wdata_o and s_rw_o, outputs, ADDR_W, DATA_W and 1, carrying the granted master's signals.
REQ-015 SHALL have s_rdata_i, input, NUM_SLAVES*DATA_W, per-slave read data.
REQ-016 SHALL have s_ready_i, input, NUM_SLAVES, per-slave ready.
REQ-017 SHALL have data_strobe_o, output, 1, a one-cycle transfer strobe.
REQ-018 SHALL have error_o, output, 1, a one-cycle error pulse.
REQ-019 SHALL have error_code_o, output, 2, last error code: 00 none, 01 decode miss, 10 timeout.

Function
REQ-020 SHALL implement FSM states IDLE, GRANT, WAIT, STROBE and RELEASE.
REQ-021 IDLE: when any barq_i bit is high, SHALL register a one-hot winner into bagd_o and go to GRANT in the next cycle; otherwise SHALL stay in IDLE with bagd_o = 0.
REQ-022 Fixed priority: the lowest-index requester SHALL win.
REQ-023 Round-robin: search SHALL start at (last granted + 1) modulo NUM_MASTERS; the pointer resets to NUM_MASTERS-1, so master 0 has first priority after reset.
REQ-024 s_addr_o, s_wdata_o and s_rw_o SHALL be a combinational mux of the master selected by bagd_o, and SHALL be 0 when bagd_o = 0.
REQ-025 GRANT: decode SHALL compute hit[i] = (addr >= BASE_i) and (addr <= BASE_i + SIZE_i - 1); SIZE_i = 0 SHALL mean never hit; on overlapping regions the lowest index wins.
REQ-026 GRANT: the one-hot hit vector SHALL be registered into s_sel_o; next state is WAIT.
REQ-027 GRANT: if no region hits, the block SHALL pulse error_o, set error_code_o = 01 and go to RELEASE.
REQ-028 WAIT: the wait counter SHALL clear on entry and increment each cycle.
REQ-029 WAIT: s_ready_i of the selected slave high SHALL move the FSM to STROBE.
REQ-030 WAIT: if the counter reaches CLK_MAX_TIMEOUT with ready still low, the block SHALL pulse error_o, set error_code_o = 10 and go to RELEASE; ready arriving in that same cycle SHALL take precedence over the timeout.
REQ-031 STROBE: data_strobe_o SHALL be 1 for exactly one cycle; on a read (s_rw_o = 0) m_rdata_o SHALL capture s_rdata_i of the selected slave; on a write, m_rdata_o SHALL hold its value; error_code_o SHALL be set to 00; next state is RELEASE.
REQ-032 RELEASE: bagd_o and s_sel_o SHALL clear to 0 for one cycle, then the FSM returns to IDLE.
REQ-033 A master still holding barq_i after RELEASE SHALL be re-arbitrated like any other requester, so minimum transfer period is 5 cycles.
REQ-034 Deassertion of the granted master's barq_i during GRANT or WAIT SHALL NOT abort the transaction.
REQ-035 m_rdata_o and error_code_o SHALL hold their values between transactions.

Reset
REQ-036 On rst_n low, asynchronously: FSM = IDLE, bagd_o = 0, s_sel_o = 0, data_strobe_o = 0, error_o = 0, error_code_o = 00, m_rdata_o = 0, wait counter = 0, RR pointer = NUM_MASTERS-1.
REQ-037 Reset asserted mid-transaction SHALL abort it with no strobe and no error pulse.

Verification (NUM_MASTERS=2, NUM_SLAVES=2, slave0 0x0000/0x100, slave1 0x0100/0x10, timeout 12)
REQ-038 Master0 reads 0x0005, slave0 ready at the first WAIT cycle, s_rdata=0xBEEF -> bagd_o=01, s_sel_o=01, one data_strobe_o, m_rdata_o=0xBEEF, error_o never high.
REQ-039 Master1 writes 0x0110 -> decode miss: error_o pulse, error_code_o=01, no strobe, bagd_o cleared after RELEASE.
REQ-040 Master0 reads 0x0100 with slave1 ready held low -> error_o pulses after 12 WAIT cycles, error_code_o=10, data_strobe_o stays 0.
REQ-041 ARB_MODE=1, both barq_i held high -> grants alternate 01, 10, 01, 10; ARB_MODE=0 -> grant always 01.
REQ-042 rst_n pulsed low during WAIT -> all outputs 0 immediately; the next request is served normally.
